serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit, request to begin an addition.
REQ-005 The block SHALL have ports a and b, input, WIDTH bits each, operands sampled only on an accepted start.
REQ-006 The block SHALL have port cin, input, 1 bit, carry-in sampled only on an accepted start.
REQ-007 The block SHALL have port busy, output, 1 bit, high while state is RUN.
REQ-008 The block SHALL have port done, output, 1 bit, one-cycle pulse when a result is written.
REQ-009 The block SHALL have ports sum (output, WIDTH bits) and cout (output, 1 bit), the registered result.

Function
REQ-010 The block SHALL compute a+b+cin bit-serially, LSB first, one full-adder bit per clock, with a single carry flop between bits.
REQ-011 The state machine SHALL have states IDLE, RUN and DONE.
REQ-012 In IDLE or DONE, start=1 at an edge SHALL load a, b into shift registers, load cin into the carry flop, clear the bit counter and enter RUN.
REQ-013 In DONE with start=0, the state SHALL return to IDLE on the next edge.
REQ-014 In RUN, each edge SHALL compute s=a0^b0^c and c'=(a0&b0)|(c&(a0^b0)), shift s into the result register at the MSB, shift the operand registers right by one and increment the counter.
REQ-015 The WIDTH-th RUN edge SHALL copy the completed result to sum, copy the final carry to cout and enter DONE.
REQ-016 Latency SHALL be exactly WIDTH edges from the start-accepting edge to the edge that enters DONE; done is high for the following cycle only.
REQ-017 start while in RUN SHALL be ignored, with no effect on operands, counter or outputs.
REQ-018 sum and cout SHALL change only at the edge entering DONE and SHALL hold their value otherwise, including through IDLE and a following RUN.
REQ-019 A start in DONE SHALL begin a new operation with no idle cycle, so done=1 and busy=0 in that cycle, then busy=1 at the next cycle.
REQ-020 Carry out of bit WIDTH-1 SHALL appear only on cout; sum SHALL wrap modulo 2^WIDTH.
REQ-021 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never exceed WIDTH.

Reset
REQ-022 rst_n=0 SHALL immediately, without a clock, force state IDLE, busy=0, done=0, sum=0, cout=0, carry flop 0, counter 0 and operand registers 0.
REQ-023 Reset asserted mid-RUN SHALL abandon the operation with no done pulse; sum and cout SHALL read 0.
REQ-024 After rst_n deasserts, the first edge with start=1 SHALL be accepted.

Configuration
REQ-025 With macro SERIAL_ADD_SUB_EN defined, the block SHALL have input sub (1 bit, sampled on accepted start); when sub=1 it SHALL load ~b and force the carry flop to 1, ignoring cin, giving a-b with cout=1 meaning no borrow.
REQ-026 Without SERIAL_ADD_SUB_EN, the sub port and its logic SHALL be absent, and behaviour SHALL be addition only.

Verification (WIDTH=8)
REQ-027 Apply a=0x00, b=0x00, cin=0, start for 1 cycle -> busy high for 8 cycles, then done pulse with sum=0x00, cout=0.
REQ-028 Apply a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; apply a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1.
REQ-029 Hold start=1 continuously, first with a=0x12, b=0x34 -> results 0x46 arrive every 9 cycles; operand changes during RUN have no effect.
REQ-030 Drop rst_n on the 4th RUN cycle of a=0x7F, b=0x01 -> outputs are 0 at once, with no done pulse; the next start with 0x03+0x04 gives 0x07.
REQ-031 With SERIAL_ADD_SUB_EN defined, apply sub=1, a=0x05, b=0x07 -> sum=0xFE, cout=0; apply sub=1, a=0x07, b=0x05 -> sum=0x02, cout=1.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// serial_add_ctrl
//
// Bit-serial adder with start/busy/done handshake. Computes a + b + cin one
// full-adder bit per clock, LSB first, through a single carry flop. The
// result register fills from the MSB side. When the last bit is done, it is
// copied to sum/cout and done pulses for one cycle.
//
// Optional feature (compile-time macro SERIAL_ADD_SUB_EN):
//   Adds input 'sub'. When sub=1 on an accepted start, ~b is loaded and the
//   carry flop is forced to 1, so the result is a - b. In that case cout=1
//   means no borrow. Without the macro the port does not exist and the block
//   only adds.
//
// Ports
//   clk    in   single clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request a new operation (ignored while busy)
//   a, b   in   WIDTH-bit operands, sampled on an accepted start
//   cin    in   carry-in, sampled on an accepted start
//   sub    in   (SERIAL_ADD_SUB_EN only) subtract select, sampled on start
//   busy   out  high while the serial loop is running
//   done   out  one-cycle pulse when sum/cout are written
//   sum    out  WIDTH-bit registered result (wraps modulo 2^WIDTH)
//   cout   out  registered carry out of bit WIDTH-1
// ---------------------------------------------------------------------------
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // The counter must be able to hold the value WIDTH.
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;

    logic             s_bit;
    logic             c_next;
    logic [WIDTH-1:0] res_next;
    logic             last_bit;
    logic             accept;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    // Select the operand and carry values that are loaded on an accepted start.
    always_comb begin
        b_load = b;
        c_load = cin;
`ifdef SERIAL_ADD_SUB_EN
        // Two's-complement subtract: a + ~b + 1. cin is ignored here.
        if (sub) begin
            b_load = ~b;
            c_load = 1'b1;
        end
`endif
    end

    // One full-adder slice working on the current LSBs.
    assign s_bit    = a_q[0] ^ b_q[0] ^ carry_q;
    assign c_next   = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
    assign res_next = {s_bit, res_q[WIDTH-1:1]};

    // The counter still holds WIDTH-1 on the edge that computes the last bit.
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    // A start is taken in IDLE or DONE. A start seen in RUN has no effect.
    assign accept   = start && (state_q != StRun);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_q     <= a;
                b_q     <= b_load;
                carry_q <= c_load;
                cnt_q   <= '0;
                busy    <= 1'b1;
                state_q <= StRun;
            end else begin
                unique case (state_q)
                    StIdle: ;
                    StRun: begin
                        res_q   <= res_next;
                        carry_q <= c_next;
                        a_q     <= {1'b0, a_q[WIDTH-1:1]};
                        b_q     <= {1'b0, b_q[WIDTH-1:1]};
                        cnt_q   <= cnt_q + CW'(1);
                        if (last_bit) begin
                            // Publish the finished word. sum/cout are written only here.
                            sum     <= res_next;
                            cout    <= c_next;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state_q <= StDone;
                        end
                    end
                    StDone: state_q <= StIdle;
                    default: begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        int           due;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at #1 after an edge. The next edge accepts, and WIDTH RUN edges
    // follow, so done is visible once cyc reaches cyc + 1 + W.
    task automatic push(input logic [W-1:0] s, input logic c);
        exp_t e;
        e.s   = s;
        e.c   = c;
        e.due = cyc + 1 + W;
        q.push_back(e);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [W-1:0] hold_s   = '0;
    logic         hold_c   = 1'b0;
    int           run_len  = 0;
    logic         prev_done = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_outputs", {busy, done, cout, sum}, 0);
            hold_s    = '0;
            hold_c    = 1'b0;
            run_len   = 0;
            prev_done = 1'b0;
        end else begin
            if (done) begin
                check("done_single_cycle", prev_done, 0);
                if (q.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("sum", sum, e.s);
                    check("cout", cout, e.c);
                    check("done_latency_cycle", cyc, e.due);
                    check("busy_run_length", run_len, W);
                    check("busy_low_in_done", busy, 0);
                    hold_s = e.s;
                    hold_c = e.c;
                end
                run_len = 0;
            end else begin
                check("result_hold", {cout, sum}, {hold_c, hold_s});
            end
            if (busy) run_len++;
            prev_done = done;
        end
    end

    // ---------------- stimulus ----------------
    task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                      input logic tsub, input logic [W-1:0] es, input logic ec);
        int g = 0;
        while (busy && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 100) check("wait_not_busy_timeout", 1, 0);
        a = ta; b = tb_v; cin = tc; sub = tsub; start = 1'b1;
        push(es, ec);
        @(posedge clk); #1;
        // Only the values present at the accepting edge may count.
        start = 1'b0;
        a = ~ta; b = ~tb_v; cin = ~tc; sub = ~tsub;
    endtask

    task automatic drain();
        int g = 0;
        while (q.size() != 0 && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        check("queue_drained", q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #3;
        check("async_reset_busy_done", {busy, done}, 0);
        check("async_reset_sum_cout", {cout, sum}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Zero operands; the first start after reset is taken at once.
        op(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        drain();
        op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
        drain();
        op(8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1);
        drain();
        op(8'h3C, 8'h0F, 1'b1, 1'b0, 8'h4C, 1'b0);
        drain();
        op(8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1);
        drain();

        // Hold start high: results every W+1 cycles, with operand noise during RUN.
        a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0; start = 1'b1;
        push(8'h46, 1'b0);
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k <= W; k++) begin
                @(posedge clk); #1;
                if (k < W) begin
                    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
                end
            end
            a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0;
            if (r < 2) push(8'h46, 1'b0);
            else start = 1'b0;
        end
        drain();

        // Reset during the 4th RUN cycle abandons the operation.
        a = 8'h7F; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_run_busy_before_reset", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_run_reset_busy_done", {busy, done}, 0);
        check("mid_run_reset_sum_cout", {cout, sum}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (W + 2) @(posedge clk);
        #1;
        op(8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0);
        drain();

`ifdef SERIAL_ADD_SUB_EN
        op(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0);
        drain();
        op(8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1);
        drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
